// File: rtl/fmac_mul_arbiter.sv
// Round-robin issue of two requesters onto one fixed-latency mantissa multiplier.
// Credits reserve result-FIFO space up front because the multiplier pipeline cannot stall.
module fmac_mul_arbiter #(
  parameter int unsigned C_MANT     = 23,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic [1:0]               Req_Valid_SI,
  output logic [1:0]               Req_Ready_SO,
  input  logic [1:0][C_MANT:0]     Req_Mant_a_DI,
  input  logic [1:0][C_MANT:0]     Req_Mant_b_DI,
  input  logic [1:0][TAG_W-1:0]    Req_Tag_DI,
  output logic                     Mul_Valid_SO,
  output logic [C_MANT:0]          Mul_Mant_a_DO,
  output logic [C_MANT:0]          Mul_Mant_b_DO,
  input  logic [2*C_MANT+1:0]      Mul_Prod_DI,
  output logic [1:0]               Res_Valid_SO,
  input  logic [1:0]               Res_Ready_SI,
  output logic [1:0][2*C_MANT+1:0] Res_Prod_DO,
  output logic [1:0][TAG_W-1:0]    Res_Tag_DO
);

  localparam int unsigned PW = 2*C_MANT+2;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST   = AW'(FIFO_DEPTH-1);

  logic [1:0][CW-1:0] credit_q, credit_d;
  logic               rr_q, rr_d;
  logic [1:0]         eligible, grant, push, pop, res_vld;

  logic [MUL_LAT-1:0]            ifl_vld_q, ifl_vld_d;
  logic [MUL_LAT-1:0]            ifl_req_q, ifl_req_d;
  logic [MUL_LAT-1:0][TAG_W-1:0] ifl_tag_q, ifl_tag_d;

  logic [1:0][FIFO_DEPTH-1:0][PW-1:0]    fifo_prod_q;
  logic [1:0][FIFO_DEPTH-1:0][TAG_W-1:0] fifo_tag_q;
  logic [1:0][AW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][CW-1:0]                    cnt_q, cnt_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Grant is suppressed during reset so nothing handshakes against state being cleared.
  always_comb begin
    eligible[0] = Req_Valid_SI[0] & (credit_q[0] != '0);
    eligible[1] = Req_Valid_SI[1] & (credit_q[1] != '0);
    grant       = '0;
    if (!Rst_RI) begin
      if (&eligible) grant[rr_q] = 1'b1;
      else           grant       = eligible;
    end
    rr_d = (|grant) ? grant[0] : rr_q;
  end

  assign Req_Ready_SO = grant;
  assign Mul_Valid_SO = |grant;

  always_comb begin
    Mul_Mant_a_DO = '0;
    Mul_Mant_b_DO = '0;
    if (grant[0]) begin
      Mul_Mant_a_DO = Req_Mant_a_DI[0];
      Mul_Mant_b_DO = Req_Mant_b_DI[0];
    end else if (grant[1]) begin
      Mul_Mant_a_DO = Req_Mant_a_DI[1];
      Mul_Mant_b_DO = Req_Mant_b_DI[1];
    end
  end

  always_comb begin
    ifl_vld_d[0] = |grant;
    ifl_req_d[0] = grant[1];
    ifl_tag_d[0] = grant[1] ? Req_Tag_DI[1] : Req_Tag_DI[0];
    for (int i = 1; i < MUL_LAT; i++) begin
      ifl_vld_d[i] = ifl_vld_q[i-1];
      ifl_req_d[i] = ifl_req_q[i-1];
      ifl_tag_d[i] = ifl_tag_q[i-1];
    end
  end

  // Last in-flight stage lines up with the product on Mul_Prod_DI.
  always_comb begin
    push[0] = ifl_vld_q[MUL_LAT-1] & ~ifl_req_q[MUL_LAT-1];
    push[1] = ifl_vld_q[MUL_LAT-1] &  ifl_req_q[MUL_LAT-1];
    for (int r = 0; r < 2; r++) begin
      res_vld[r]     = (cnt_q[r] != '0);
      pop[r]         = res_vld[r] & Res_Ready_SI[r];
      Res_Prod_DO[r] = res_vld[r] ? fifo_prod_q[r][rd_ptr_q[r]] : '0;
      Res_Tag_DO[r]  = res_vld[r] ? fifo_tag_q[r][rd_ptr_q[r]]  : '0;
    end
  end

  assign Res_Valid_SO = res_vld;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      credit_d[r] = credit_q[r];
      if (grant[r] && !pop[r])      credit_d[r] = credit_q[r] - CW'(1);
      else if (pop[r] && !grant[r]) credit_d[r] = credit_q[r] + CW'(1);
      cnt_d[r] = cnt_q[r];
      if (push[r] && !pop[r])       cnt_d[r] = cnt_q[r] + CW'(1);
      else if (pop[r] && !push[r])  cnt_d[r] = cnt_q[r] - CW'(1);
      wr_ptr_d[r] = push[r] ? ptr_inc(wr_ptr_q[r]) : wr_ptr_q[r];
      rd_ptr_d[r] = pop[r]  ? ptr_inc(rd_ptr_q[r]) : rd_ptr_q[r];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      credit_q  <= {2{CREDIT_MAX}};
      rr_q      <= 1'b0;
      ifl_vld_q <= '0;
      ifl_req_q <= '0;
      ifl_tag_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      credit_q  <= credit_d;
      rr_q      <= rr_d;
      ifl_vld_q <= ifl_vld_d;
      ifl_req_q <= ifl_req_d;
      ifl_tag_q <= ifl_tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: heads are masked by the occupancy count.
  always_ff @(posedge Clk_CI) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        fifo_prod_q[r][wr_ptr_q[r]] <= Mul_Prod_DI;
        fifo_tag_q[r][wr_ptr_q[r]]  <= ifl_tag_q[MUL_LAT-1];
      end
    end
  end

  for (genvar r = 0; r < 2; r++) begin : g_ovf
    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
      !(push[r] && (cnt_q[r] == CREDIT_MAX)));
  end

endmodule

// File: tb/tb_fmac_mul_arbiter.sv
// Directed and random checks of fmac_mul_arbiter against a behavioural multiplier
// and a per-requester result scoreboard.
module tb_fmac_mul_arbiter;
  localparam int C_MANT = 23, MUL_LAT = 2, FIFO_DEPTH = 2, TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            req_valid, req_ready, res_valid, res_ready;
  logic [1:0][23:0]      a, b;
  logic [1:0][3:0]       tag;
  logic                  mul_valid;
  logic [23:0]           mul_a, mul_b;
  logic [47:0]           mul_prod;
  logic [1:0][47:0]      res_prod;
  logic [1:0][3:0]       res_tag;

  fmac_mul_arbiter #(.C_MANT(C_MANT), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .Req_Valid_SI(req_valid), .Req_Ready_SO(req_ready),
    .Req_Mant_a_DI(a), .Req_Mant_b_DI(b), .Req_Tag_DI(tag),
    .Mul_Valid_SO(mul_valid), .Mul_Mant_a_DO(mul_a), .Mul_Mant_b_DO(mul_b),
    .Mul_Prod_DI(mul_prod),
    .Res_Valid_SO(res_valid), .Res_Ready_SI(res_ready),
    .Res_Prod_DO(res_prod), .Res_Tag_DO(res_tag)
  );

  // Multiplier model keeps running through reset so stale products do arrive.
  logic [47:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? (48'(mul_a) * 48'(mul_b)) : 48'hBAD0_0BAD_0BAD;
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_prod = mpipe[MUL_LAT-1];

  bit          chk_rdy, chk_resv, chk_prod, chk_zero, final_chk, hold_ops;
  logic [1:0]  exp_rdy, exp_resv;
  logic [47:0] exp_prod;
  logic [3:0]  exp_tag;
  int          errors = 0, checks = 0;
  logic [51:0] q0[$], q1[$];

  always @(negedge clk) begin
    logic [23:0] want_a;
    logic [51:0] e;
    if (rst) begin
      q0.delete();
      q1.delete();
    end
    if (chk_rdy) begin
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL ready: got %b want %b at %0t", req_ready, exp_rdy, $time);
      end
      checks++;
      if (mul_valid !== (exp_rdy != 2'b00)) begin
        errors++; $display("FAIL mul_valid: got %b want %b at %0t", mul_valid, exp_rdy != 2'b00, $time);
      end
      want_a = exp_rdy[0] ? a[0] : (exp_rdy[1] ? a[1] : 24'h0);
      checks++;
      if (mul_a !== want_a) begin
        errors++; $display("FAIL mul_a: got %h want %h at %0t", mul_a, want_a, $time);
      end
    end
    if (chk_resv) begin
      checks++;
      if (res_valid !== exp_resv) begin
        errors++; $display("FAIL res_valid: got %b want %b at %0t", res_valid, exp_resv, $time);
      end
    end
    if (chk_prod) begin
      checks++;
      if (res_prod[0] !== exp_prod || res_tag[0] !== exp_tag) begin
        errors++; $display("FAIL first_prod: got %h/%h want %h/%h", res_prod[0], res_tag[0], exp_prod, exp_tag);
      end
    end
    if (chk_zero) begin
      checks++;
      if (res_prod !== '0 || res_tag !== '0) begin
        errors++; $display("FAIL zero_data: got %h/%h want 0 at %0t", res_prod, res_tag, $time);
      end
    end
    if (!rst) begin
      checks++;
      if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) begin
        errors++; $display("FAIL grant_legal: ready %b valid %b at %0t", req_ready, req_valid, $time);
      end
      if (req_ready == 2'b00) begin
        checks++;
        if (mul_valid !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
          errors++; $display("FAIL idle_mul: got v=%b a=%h b=%h want 0", mul_valid, mul_a, mul_b);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          checks++;
          if (!mul_valid || mul_a !== a[r] || mul_b !== b[r]) begin
            errors++; $display("FAIL mux%0d: got %h*%h want %h*%h", r, mul_a, mul_b, a[r], b[r]);
          end
          e = {48'(a[r]) * 48'(b[r]), tag[r]};
          if (r == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (res_valid[r] && res_ready[r]) begin
          checks++;
          if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
            errors++; $display("FAIL sb_unexpected%0d: got %h/%h want nothing", r, res_prod[r], res_tag[r]);
          end else begin
            e = (r == 0) ? q0.pop_front() : q1.pop_front();
            if ({res_prod[r], res_tag[r]} !== e) begin
              errors++; $display("FAIL sb%0d: got %h/%h want %h/%h", r, res_prod[r], res_tag[r], e[51:4], e[3:0]);
            end
          end
        end
      end
    end
    if (final_chk) begin
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
        errors++; $display("FAIL drain: got %0d/%0d outstanding want 0/0", q0.size(), q1.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    chk_rdy = 0; chk_resv = 0; chk_prod = 0; chk_zero = 0;
    if (!hold_ops) begin
      for (int r = 0; r < 2; r++) begin
        a[r] = 24'($urandom); b[r] = 24'($urandom); tag[r] = 4'($urandom);
      end
    end
  endtask

  task automatic go(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] er, input logic [1:0] es);
    cyc();
    rst = 0; req_valid = v; res_ready = rr;
    exp_rdy = er; exp_resv = es; chk_rdy = 1; chk_resv = 1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      rst = 1; req_valid = 2'b11; res_ready = 2'b11;
      exp_rdy = 2'b00; chk_rdy = 1;
      if (i > 0) begin
        exp_resv = 2'b00; chk_resv = 1; chk_zero = 1;
      end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; res_ready = 0; hold_ops = 1;
    chk_rdy = 0; chk_resv = 0; chk_prod = 0; chk_zero = 0; final_chk = 0;
    exp_rdy = 0; exp_resv = 0; exp_prod = 0; exp_tag = 0;
    a[0] = 24'h800000; b[0] = 24'h800000; tag[0] = 4'd3;
    a[1] = 24'h123456; b[1] = 24'h00ABCD; tag[1] = 4'd5;
    do_reset(3);

    // single r0 op: latency, value, credit returns to 2 after the pop
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b00, 2'b00, 2'b00, 2'b00);
    go(2'b00, 2'b00, 2'b00, 2'b00);
    go(2'b00, 2'b01, 2'b00, 2'b01);
    chk_prod = 1; exp_prod = 48'h4000_0000_0000; exp_tag = 4'd3;
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b00, 2'b00);
    go(2'b01, 2'b00, 2'b00, 2'b01);

    // both requesters always valid, results always drained: strict alternation
    hold_ops = 0;
    do_reset(2);
    for (int i = 0; i < 8; i++)
      go(2'b11, 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10,
         (i < 3) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10));

    // r0 results held back: r0 runs out of credit, one pop buys one grant
    do_reset(2);
    go(2'b11, 2'b10, 2'b01, 2'b00);
    go(2'b11, 2'b10, 2'b10, 2'b00);
    go(2'b11, 2'b10, 2'b01, 2'b00);
    go(2'b11, 2'b10, 2'b10, 2'b01);
    go(2'b11, 2'b10, 2'b00, 2'b11);
    go(2'b11, 2'b10, 2'b10, 2'b01);
    go(2'b11, 2'b10, 2'b00, 2'b11);
    go(2'b11, 2'b10, 2'b10, 2'b01);
    go(2'b11, 2'b10, 2'b00, 2'b11);
    go(2'b11, 2'b10, 2'b10, 2'b01);
    go(2'b11, 2'b11, 2'b00, 2'b11);
    go(2'b11, 2'b10, 2'b01, 2'b01);
    go(2'b11, 2'b10, 2'b10, 2'b11);
    go(2'b11, 2'b10, 2'b10, 2'b01);

    // fill r0 FIFO, then pop and issue in the same cycle
    do_reset(2);
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b00, 2'b00);
    go(2'b01, 2'b00, 2'b00, 2'b01);
    go(2'b01, 2'b01, 2'b00, 2'b01);
    go(2'b01, 2'b01, 2'b01, 2'b01);
    go(2'b01, 2'b01, 2'b01, 2'b00);
    go(2'b01, 2'b01, 2'b00, 2'b00);
    go(2'b01, 2'b01, 2'b00, 2'b01);

    // reset with two ops in flight: stale products dropped, credits restored
    do_reset(2);
    go(2'b11, 2'b00, 2'b01, 2'b00);
    go(2'b11, 2'b00, 2'b10, 2'b00);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      go(2'b00, 2'b00, 2'b00, 2'b00);
      chk_zero = 1;
    end
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b01, 2'b00);
    go(2'b01, 2'b00, 2'b00, 2'b00);

    // random soak against the scoreboard
    do_reset(2);
    for (int i = 0; i < 10000; i++) begin
      cyc();
      rst = 0; req_valid = 2'($urandom); res_ready = 2'($urandom);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      req_valid = 2'b00; res_ready = 2'b11;
    end
    cyc();
    final_chk = 1;
    cyc();
    final_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
